// File: rtl/alu_input_pkg.sv
// Shared encodings for the ALU input sequencer: sequence states, button indices, mode values.
package alu_input_pkg;

    typedef enum logic [1:0] {
        S_A   = 2'd0,
        S_B   = 2'd1,
        S_OP  = 2'd2,
        S_RES = 2'd3
    } seq_state_t;

    localparam int BTN_A  = 0;
    localparam int BTN_B  = 1;
    localparam int BTN_OP = 2;

    localparam logic MODE_FREE = 1'b0;
    localparam logic MODE_SEQ  = 1'b1;

    // Same-cycle presses resolve to a single winner, lowest index first.
    function automatic logic [2:0] btn_priority(input logic [2:0] press);
        if (press[BTN_A])       return 3'b001;
        else if (press[BTN_B])  return 3'b010;
        else if (press[BTN_OP]) return 3'b100;
        else                    return 3'b000;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// One button: 2-FF synchroniser, stable-count debounce, one-cycle pulse on the accepted rising level.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 1000
)(
    input  logic clk,
    input  logic rst_n,
    input  logic i_btn,
    output logic o_press
);

    localparam int             CW      = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CW-1:0]  CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]    r_sync;
    logic          r_level;
    logic [CW-1:0] r_cnt;
    logic          r_press;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync  <= 2'b00;
            r_level <= 1'b0;
            r_cnt   <= '0;
            r_press <= 1'b0;
        end else begin
            r_sync  <= {r_sync[0], i_btn};
            r_press <= 1'b0;
            if (r_sync[1] != r_level) begin
                if (r_cnt == CNT_MAX) begin
                    r_level <= r_sync[1];
                    r_cnt   <= '0;
                    r_press <= r_sync[1];
                end else begin
                    r_cnt <= r_cnt + CW'(1);
                end
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign o_press = r_press;

endmodule

// File: rtl/alu_input_sequencer.sv
// Button/switch front end for an external ALU: operand/opcode capture, free or guided A->B->OP entry.
// Build option ALU_SEQ_TIMEOUT_EN adds a per-step idle timeout (TIMEOUT_CYCLES) in sequenced mode.
//   state | meaning
//   S_A   | waiting for operand A (also the only state in free mode)
//   S_B   | waiting for operand B
//   S_OP  | waiting for opcode
//   S_RES | result captured, valid; a new A restarts the sequence
module alu_input_sequencer
    import alu_input_pkg::*;
#(
    parameter int NB_DATA         = 8,
    parameter int NB_OP           = 6,
    parameter int DEBOUNCE_CYCLES = 1000,
    parameter int TIMEOUT_CYCLES  = 50000000
)(
    input  logic               clk,
    input  logic               rst_n,
    input  logic [2:0]         i_btn,
    input  logic [NB_DATA-1:0] i_sw_data,
    input  logic               i_mode,
    input  logic [NB_DATA-1:0] i_alu_result,
    input  logic               i_alu_carry,
    input  logic               i_alu_zero,
    output logic [NB_DATA-1:0] o_a,
    output logic [NB_DATA-1:0] o_b,
    output logic [NB_OP-1:0]   o_op,
    output logic [NB_DATA-1:0] o_leds_result,
    output logic               o_carry,
    output logic               o_zero,
    output logic               o_result_valid,
    output logic [1:0]         o_state
);

    if (NB_OP > NB_DATA || DEBOUNCE_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_param_err
        $error("alu_input_sequencer: illegal parameter combination");
    end

    logic [2:0]         w_press;
    logic [2:0]         w_win;
    logic               w_mode_chg;
    seq_state_t         r_state;
    seq_state_t         w_state_next;
    logic               r_mode;
    logic [2:0]         r_mask;
    logic               r_cap_pend;
    logic               w_cap_next;
    logic               w_load_a;
    logic               w_load_b;
    logic               w_load_op;
    logic               w_clr_valid;
    logic [NB_DATA-1:0] r_a;
    logic [NB_DATA-1:0] r_b;
    logic [NB_OP-1:0]   r_op;
    logic [NB_DATA-1:0] r_res;
    logic               r_carry;
    logic               r_zero;
    logic               r_valid;

    for (genvar gi = 0; gi < 3; gi++) begin : g_btn
        btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn (
            .clk     (clk),
            .rst_n   (rst_n),
            .i_btn   (i_btn[gi]),
            .o_press (w_press[gi])
        );
    end

    assign w_win      = btn_priority(w_press);
    assign w_mode_chg = (i_mode != r_mode);

`ifdef ALU_SEQ_TIMEOUT_EN
    localparam int               TMO_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(TIMEOUT_CYCLES - 1);
    logic [TMO_W-1:0] r_tmo;
    logic             w_tmo_run;
`endif

    always_comb begin
        w_state_next = r_state;
        w_cap_next   = 1'b0;
        w_load_a     = 1'b0;
        w_load_b     = 1'b0;
        w_load_op    = 1'b0;
        w_clr_valid  = 1'b0;
        if (w_mode_chg) begin
            w_state_next = S_A;
        end else if (r_mode == MODE_FREE) begin
            w_load_a     = w_win[BTN_A];
            w_load_b     = w_win[BTN_B];
            w_load_op    = w_win[BTN_OP];
            w_cap_next   = |w_win;
            w_state_next = S_A;
        end else begin
            case (r_state)
                S_A:   if (w_win[BTN_A])  begin w_load_a  = 1'b1; w_state_next = S_B;   end
                S_B:   if (w_win[BTN_B])  begin w_load_b  = 1'b1; w_state_next = S_OP;  end
                S_OP:  if (w_win[BTN_OP]) begin w_load_op = 1'b1; w_state_next = S_RES; w_cap_next = 1'b1; end
                S_RES: if (w_win[BTN_A])  begin w_load_a  = 1'b1; w_state_next = S_B;   w_clr_valid = 1'b1; end
                default: w_state_next = S_A;
            endcase
        end
`ifdef ALU_SEQ_TIMEOUT_EN
        // Counter only runs while parked in S_B/S_OP; any transition reloads it.
        w_tmo_run = !w_mode_chg && (r_mode == MODE_SEQ) && (r_state == S_B || r_state == S_OP)
                    && (w_state_next == r_state);
        if (w_tmo_run && r_tmo == '0) begin
            w_state_next = S_A;
        end
`endif
    end

`ifdef ALU_SEQ_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_tmo <= TMO_MAX;
        end else if (w_tmo_run && r_tmo != '0) begin
            r_tmo <= r_tmo - TMO_W'(1);
        end else begin
            r_tmo <= TMO_MAX;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= S_A;
            r_mode     <= MODE_FREE;
            r_mask     <= 3'b000;
            r_cap_pend <= 1'b0;
            r_a        <= '0;
            r_b        <= '0;
            r_op       <= '0;
            r_res      <= '0;
            r_carry    <= 1'b0;
            r_zero     <= 1'b0;
            r_valid    <= 1'b0;
        end else begin
            r_mode     <= i_mode;
            r_state    <= w_state_next;
            r_cap_pend <= w_cap_next;
            if (w_load_a)  r_a  <= i_sw_data;
            if (w_load_b)  r_b  <= i_sw_data;
            if (w_load_op) r_op <= i_sw_data[NB_OP-1:0];
            if (w_mode_chg) r_mask <= 3'b000;
            else            r_mask <= r_mask | {w_load_op, w_load_b, w_load_a};
            // The ALU sees the new operands one cycle after the load, so capture lags by one.
            if (r_cap_pend) begin
                r_res   <= i_alu_result;
                r_carry <= i_alu_carry;
                r_zero  <= i_alu_zero;
            end
            if (w_mode_chg || w_clr_valid) r_valid <= 1'b0;
            else if (r_cap_pend)           r_valid <= (r_mode == MODE_FREE) ? (r_mask == 3'b111) : 1'b1;
        end
    end

    assign o_a            = r_a;
    assign o_b            = r_b;
    assign o_op           = r_op;
    assign o_leds_result  = r_res;
    assign o_carry        = r_carry;
    assign o_zero         = r_zero;
    assign o_result_valid = r_valid;
    assign o_state        = r_state;

endmodule

// File: tb/tb_alu_input_sequencer.sv
// Bench for alu_input_sequencer: directed scenarios plus random button/switch/mode traffic vs a reference model.
// Define ALU_SEQ_TIMEOUT_EN for both bench and RTL to exercise the step timeout.
module tb_alu_input_sequencer;

    localparam int D = 4;
    localparam int T = 10;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] i_btn;
    logic [7:0] i_sw_data;
    logic       i_mode;
    logic [7:0] i_alu_result;
    logic       i_alu_carry;
    logic       i_alu_zero;
    logic [7:0] o_a, o_b, o_leds_result;
    logic [5:0] o_op;
    logic       o_carry, o_zero, o_result_valid;
    logic [1:0] o_state;
    logic [8:0] alu_out;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    alu_input_sequencer #(
        .NB_DATA(8), .NB_OP(6), .DEBOUNCE_CYCLES(D), .TIMEOUT_CYCLES(T)
    ) dut (
        .clk(clk), .rst_n(rst_n), .i_btn(i_btn), .i_sw_data(i_sw_data), .i_mode(i_mode),
        .i_alu_result(i_alu_result), .i_alu_carry(i_alu_carry), .i_alu_zero(i_alu_zero),
        .o_a(o_a), .o_b(o_b), .o_op(o_op), .o_leds_result(o_leds_result),
        .o_carry(o_carry), .o_zero(o_zero), .o_result_valid(o_result_valid), .o_state(o_state)
    );

    // External ALU: 0x22 subtract, 0x24 and, anything else add; bit 8 is carry/borrow.
    function automatic logic [8:0] alu_fn(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op);
        case (op)
            6'h22:   return {1'b0, a} - {1'b0, b};
            6'h24:   return {1'b0, a & b};
            default: return {1'b0, a} + {1'b0, b};
        endcase
    endfunction

    assign alu_out      = alu_fn(o_a, o_b, o_op);
    assign i_alu_result = alu_out[7:0];
    assign i_alu_carry  = alu_out[8];
    assign i_alu_zero   = (alu_out[7:0] == 8'h00);

    // Reference model state: what each visible register should hold after the last edge.
    logic [7:0] m_a, m_b, m_res;
    logic [5:0] m_op;
    logic       m_carry, m_zero, m_valid, m_mode, m_pend;
    logic [1:0] m_state;
    logic [2:0] m_mask;
    int         m_tmo;
    logic [2:0] m_raw1, m_raw2, m_level, m_pulse;
    int         m_run [3];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [63:0] dut_vec();
        return {29'd0, o_a, o_b, o_op, o_leds_result, o_carry, o_zero, o_result_valid, o_state};
    endfunction

    function automatic logic [63:0] model_vec();
        return {29'd0, m_a, m_b, m_op, m_res, m_carry, m_zero, m_valid, m_state};
    endfunction

    task automatic model_reset();
        m_a = 0; m_b = 0; m_op = 0; m_res = 0;
        m_carry = 0; m_zero = 0; m_valid = 0; m_mode = 0; m_pend = 0;
        m_state = 0; m_mask = 0; m_tmo = 0;
        m_raw1 = 0; m_raw2 = 0; m_level = 0; m_pulse = 0;
        for (int b = 0; b < 3; b++) m_run[b] = 0;
    endtask

    // Advance the model by one clock edge using the inputs currently applied.
    task automatic model_step();
        logic [2:0] pulse_now, pulse_next;
        logic [8:0] alu;
        int         win;
        logic [7:0] n_a, n_b, n_res;
        logic [5:0] n_op;
        logic       n_carry, n_zero, n_valid, n_mode, n_pend;
        logic [1:0] n_state;
        logic [2:0] n_mask;
        int         n_tmo;
        if (!rst_n) begin
            model_reset();
            return;
        end
        // Buttons: a level is accepted once the synchronised input has disagreed with it for D cycles.
        pulse_now  = m_pulse;
        pulse_next = 3'b000;
        for (int b = 0; b < 3; b++) begin
            if (m_raw2[b] != m_level[b]) begin
                m_run[b]++;
                if (m_run[b] == D) begin
                    m_level[b]    = m_raw2[b];
                    m_run[b]      = 0;
                    pulse_next[b] = m_raw2[b];
                end
            end else begin
                m_run[b] = 0;
            end
        end
        m_raw2  = m_raw1;
        m_raw1  = i_btn;
        m_pulse = pulse_next;

        win = -1;
        for (int b = 2; b >= 0; b--) if (pulse_now[b]) win = b;

        n_a = m_a; n_b = m_b; n_op = m_op; n_res = m_res;
        n_carry = m_carry; n_zero = m_zero; n_valid = m_valid; n_mode = m_mode;
        n_state = m_state; n_mask = m_mask; n_pend = 0; n_tmo = 0;

        if (m_pend) begin
            alu     = alu_fn(m_a, m_b, m_op);
            n_res   = alu[7:0];
            n_carry = alu[8];
            n_zero  = (alu[7:0] == 8'h00);
            n_valid = (m_mode == 1'b0) ? (m_mask == 3'b111) : 1'b1;
        end

        if (i_mode != m_mode) begin
            n_mode = i_mode; n_state = 0; n_valid = 0; n_mask = 0;
        end else if (win >= 0) begin
            if (m_mode == 1'b0) begin
                if (win == 0) n_a = i_sw_data;
                if (win == 1) n_b = i_sw_data;
                if (win == 2) n_op = i_sw_data[5:0];
                n_mask[win] = 1'b1;
                n_pend = 1;
            end else if (m_state == 0 && win == 0) begin
                n_a = i_sw_data; n_state = 1;
            end else if (m_state == 1 && win == 1) begin
                n_b = i_sw_data; n_state = 2;
            end else if (m_state == 2 && win == 2) begin
                n_op = i_sw_data[5:0]; n_state = 3; n_pend = 1;
            end else if (m_state == 3 && win == 0) begin
                n_a = i_sw_data; n_state = 1; n_valid = 0;
            end
        end
`ifdef ALU_SEQ_TIMEOUT_EN
        if (i_mode == m_mode && m_mode == 1'b1 && (m_state == 1 || m_state == 2) && n_state == m_state) begin
            if (m_tmo == T - 1) n_state = 0;
            else                n_tmo   = m_tmo + 1;
        end
`endif
        m_a = n_a; m_b = n_b; m_op = n_op; m_res = n_res;
        m_carry = n_carry; m_zero = n_zero; m_valid = n_valid; m_mode = n_mode;
        m_state = n_state; m_mask = n_mask; m_pend = n_pend; m_tmo = n_tmo;
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        chk("cycle_outputs", dut_vec(), model_vec());
    endtask

    task automatic idle(input int n);
        repeat (n) cycle();
    endtask

    // Raw press held 5 cycles; returns right after the edge that loads the register.
    task automatic press(input int idx, input logic [7:0] val);
        i_sw_data  = val;
        i_btn[idx] = 1'b1;
        repeat (5) cycle();
        i_btn[idx] = 1'b0;
        repeat (2) cycle();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int changes;
        logic [7:0] prev_b;
        int dur [3];

        rst_n = 1'b0; i_btn = 3'b000; i_sw_data = 8'h00; i_mode = 1'b0;
        model_reset();
        idle(3);
        chk("reset_outputs", dut_vec(), 64'd0);
        rst_n = 1'b1;
        idle(2);

        // Too-short press on btn0 must not load.
        i_sw_data = 8'h5A;
        i_btn[0]  = 1'b1;
        idle(3);
        i_btn[0]  = 1'b0;
        idle(10);
        chk("short_press_no_load", 64'(o_a), 64'h00);

        // Press-to-register latency.
        i_sw_data = 8'h3C;
        i_btn[0]  = 1'b1;
        n = 0;
        for (int k = 1; k <= 20; k++) begin
            cycle();
            if (o_a == 8'h3C) begin n = k; break; end
        end
        chk("press_latency", 64'(n), 64'd7);
        idle(3);
        i_btn[0]  = 1'b0;
        i_sw_data = 8'hFF;
        idle(12);
        chk("release_no_load", 64'(o_a), 64'h3C);

        // Bounce 1-0-1 then stable on btn1: a single load, at the 9th edge.
        i_btn[1] = 1'b1; cycle();
        i_btn[1] = 1'b0; cycle();
        i_btn[1] = 1'b1;
        changes = 0;
        prev_b  = o_b;
        for (int k = 0; k < 12; k++) begin
            i_sw_data = 8'h40 + 8'(k);
            cycle();
            if (o_b != prev_b) changes++;
            prev_b = o_b;
        end
        chk("bounce_single_load", 64'(changes), 64'd1);
        chk("bounce_value", 64'(o_b), 64'h46);
        i_btn[1] = 1'b0;
        idle(8);

        // Mid-operation reset leaves nothing behind.
        rst_n = 1'b0; cycle(); rst_n = 1'b1;
        chk("reset_mid_op", dut_vec(), 64'd0);
        idle(2);

        // Free mode: valid only once A, B and OP have all been loaded.
        press(0, 8'h05);
        chk("free_valid_after_a", 64'(o_result_valid), 64'd0);
        press(1, 8'h03);
        chk("free_valid_after_b", 64'(o_result_valid), 64'd0);
        press(2, 8'h20);
        chk("free_op_loaded", 64'(o_op), 64'h20);
        chk("free_valid_at_load", 64'(o_result_valid), 64'd0);
        cycle();
        chk("free_result", 64'(o_leds_result), 64'h08);
        chk("free_valid", 64'(o_result_valid), 64'd1);
        idle(6);

        // Simultaneous btn0+btn2: btn0 wins.
        i_sw_data = 8'hA5;
        i_btn     = 3'b101;
        repeat (5) cycle();
        i_btn = 3'b000;
        repeat (2) cycle();
        chk("simul_a_loaded", 64'(o_a), 64'hA5);
        chk("simul_op_kept", 64'(o_op), 64'h20);
        idle(6);

        // Sequenced mode.
        i_mode = 1'b1;
        idle(2);
        chk("seq_enter_state", 64'(o_state), 64'd0);
        chk("seq_enter_valid", 64'(o_result_valid), 64'd0);
        press(1, 8'h11);
        idle(1);
        chk("seq_b_ignored_state", 64'(o_state), 64'd0);
        chk("seq_b_ignored_value", 64'(o_b), 64'h03);
        press(0, 8'hFF);
        chk("seq_state_b", 64'(o_state), 64'd1);
        press(1, 8'h01);
        chk("seq_state_op", 64'(o_state), 64'd2);
        chk("seq_valid_in_op", 64'(o_result_valid), 64'd0);
        press(2, 8'h20);
        cycle();
        chk("seq_state_res", 64'(o_state), 64'd3);
        chk("seq_result", 64'(o_leds_result), 64'h00);
        chk("seq_carry", 64'(o_carry), 64'd1);
        chk("seq_zero", 64'(o_zero), 64'd1);
        chk("seq_valid", 64'(o_result_valid), 64'd1);
        press(0, 8'h10);
        chk("seq_restart_state", 64'(o_state), 64'd1);
        chk("seq_restart_valid", 64'(o_result_valid), 64'd0);
        press(1, 8'h22);
        chk("seq_restart_op", 64'(o_state), 64'd2);

        // Mode toggle in S_OP: back to S_A, operands kept.
        i_mode = 1'b0;
        idle(2);
        chk("mode_chg_state", 64'(o_state), 64'd0);
        chk("mode_chg_valid", 64'(o_result_valid), 64'd0);
        chk("mode_chg_operands", {40'd0, o_a, o_b, 2'b00, o_op}, {40'd0, 8'h10, 8'h22, 2'b00, 6'h20});

        // Reset while waiting in S_OP.
        i_mode = 1'b1;
        idle(2);
        press(0, 8'h33);
        press(1, 8'h44);
        chk("pre_reset_state", 64'(o_state), 64'd2);
        rst_n = 1'b0; cycle(); rst_n = 1'b1;
        chk("reset_in_op", dut_vec(), 64'd0);
        idle(2);

`ifdef ALU_SEQ_TIMEOUT_EN
        press(0, 8'h55);
        idle(T - 1);
        chk("tmo_still_b", 64'(o_state), 64'd1);
        idle(1);
        chk("tmo_back_to_a", 64'(o_state), 64'd0);
        chk("tmo_a_kept", 64'(o_a), 64'h55);
`endif

        // Random traffic on buttons, switches, mode and occasional reset.
        for (int b = 0; b < 3; b++) dur[b] = 0;
        for (int k = 0; k < 4000; k++) begin
            for (int b = 0; b < 3; b++) begin
                if (dur[b] == 0) begin
                    i_btn[b] = 1'($urandom_range(0, 1));
                    dur[b]   = $urandom_range(1, 12);
                end else begin
                    dur[b]--;
                end
            end
            i_sw_data = 8'($urandom);
            if ($urandom_range(0, 199) == 0) i_mode = ~i_mode;
            rst_n = ($urandom_range(0, 799) != 0);
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
